// File: rtl/axil_pkg.sv
// Shared AXI-Lite / UART constants plus the command-decoder opcodes, error codes and state type.
package axil_pkg;

  localparam int AXI_DATA_WIDTH_UART = 32;
  localparam int AXI_ADDR_WIDTH      = 32;

  localparam int CLOCK     = 50_000_000;
  localparam int BAUD_RATE = 115_200;
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
  localparam int DATA_BYTE = AXI_DATA_WIDTH_UART / 8;

  // Four word-times of slack between words of one command
  localparam int CMD_TIMEOUT_CYCLES =
    4 * CLOCK / BAUD_RATE * DATA_BYTE * (2 + DATA_BITS + STOP_BITS);

  localparam logic [7:0] WR_OP = 8'hA5;
  localparam logic [7:0] RD_OP = 8'h5A;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_OPCODE  = 2'b01,
    ERR_TIMEOUT = 2'b10
  } cmd_err_t;

  typedef enum logic [1:0] {
    CMD_IDLE,
    CMD_ADDR,
    CMD_DATA,
    CMD_ISSUE
  } state_type_cmd;

endpackage

// File: rtl/uart_cmd_decoder.sv
// Assembles header/address/data words from the UART RX stream into one AXI-Lite command,
// rejecting unknown opcodes and dropping commands that stall between words.
module uart_cmd_decoder
  import axil_pkg::*;
#(
  parameter int DATA_WIDTH     = AXI_DATA_WIDTH_UART,
  parameter int ADDR_WIDTH     = AXI_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = CMD_TIMEOUT_CYCLES
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic                  cmd_write,
  output logic [ADDR_WIDTH-1:0] cmd_addr,
  output logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic [1:0]            cmd_error
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  state_type_cmd         state_q;
  logic                  tready_q;
  logic                  valid_q;
  logic                  write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  cmd_err_t              err_q;
  logic [CNT_W-1:0]      cnt_q;

  logic       accept;
  logic       waiting;
  logic       timeout;
  logic [7:0] opcode;

  assign accept  = s_axis_tvalid && tready_q;
  assign opcode  = s_axis_tdata[DATA_WIDTH-1 -: 8];
  assign waiting = (state_q == CMD_ADDR) || (state_q == CMD_DATA);
  // An accepted word on the limit cycle takes priority over the timeout
  assign timeout = waiting && !accept && (cnt_q == CNT_MAX);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q  <= CMD_IDLE;
      tready_q <= 1'b1;
      valid_q  <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= ERR_NONE;
      cnt_q    <= '0;
    end else begin
      err_q <= ERR_NONE;

      if (timeout) begin
        state_q <= CMD_IDLE;
        cnt_q   <= '0;
        err_q   <= ERR_TIMEOUT;
      end else if (waiting) begin
        cnt_q <= accept ? '0 : cnt_q + CNT_W'(1);
      end

      unique case (state_q)
        CMD_IDLE: begin
          cnt_q <= '0;
          if (accept) begin
            if (opcode == WR_OP) begin
              write_q <= 1'b1;
              state_q <= CMD_ADDR;
            end else if (opcode == RD_OP) begin
              write_q <= 1'b0;
              state_q <= CMD_ADDR;
            end else begin
              err_q <= ERR_OPCODE;
            end
          end
        end

        CMD_ADDR: begin
          if (accept) begin
            addr_q <= s_axis_tdata[ADDR_WIDTH-1:0];
            if (write_q) begin
              state_q <= CMD_DATA;
            end else begin
              wdata_q  <= '0;
              valid_q  <= 1'b1;
              tready_q <= 1'b0;
              state_q  <= CMD_ISSUE;
            end
          end
        end

        CMD_DATA: begin
          if (accept) begin
            wdata_q  <= s_axis_tdata;
            valid_q  <= 1'b1;
            tready_q <= 1'b0;
            state_q  <= CMD_ISSUE;
          end
        end

        CMD_ISSUE: begin
          if (valid_q && cmd_ready) begin
            valid_q  <= 1'b0;
            tready_q <= 1'b1;
            state_q  <= CMD_IDLE;
          end
        end

        default: state_q <= CMD_IDLE;
      endcase
    end
  end

  assign s_axis_tready = tready_q;
  assign cmd_valid     = valid_q;
  assign cmd_write     = write_q;
  assign cmd_addr      = addr_q;
  assign cmd_wdata     = wdata_q;
  assign cmd_error     = err_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder: directed corner sequences, a vector table and
// randomized commands checked against a transaction-level expectation queue.
module tb_uart_cmd_decoder;
  import axil_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int T  = 12;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [1:0]    cmd_error;

  logic ready_en = 1'b0;
  logic ready_rnd = 1'b0;
  logic ready_man = 1'b0;
  assign cmd_ready = ready_en ? ready_rnd : ready_man;

  always #5 aclk = ~aclk;

  uart_cmd_decoder #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .cmd_error    (cmd_error)
  );

  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } cmd_t;

  typedef struct {
    logic [31:0] hdr;
    logic [31:0] addr;
    logic [31:0] data;
    int unsigned nwords;
    int unsigned gap;
    logic        exp_write;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [1:0]  exp_err;
  } vec_t;

  cmd_t        exp_cmd[$];
  logic [1:0]  exp_err[$];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    s_axis_tvalid = 1'b0;
    repeat (n) step();
  endtask

  task automatic send_word(input logic [DW-1:0] d);
    int unsigned n;
    n = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    while (!s_axis_tready && n < 200) begin
      step();
      n++;
    end
    if (!s_axis_tready) check("tready_wait", s_axis_tready, 1);
    step();
  endtask

  task automatic wait_idle();
    int unsigned n;
    n = 0;
    s_axis_tvalid = 1'b0;
    while (!(s_axis_tready && !cmd_valid) && n < 200) begin
      step();
      n++;
    end
    check("idle_wait", {s_axis_tready, cmd_valid}, 2'b10);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tready"}, s_axis_tready, 1);
    check({tag, "_valid"},  cmd_valid, 0);
    check({tag, "_write"},  cmd_write, 0);
    check({tag, "_addr"},   cmd_addr, 0);
    check({tag, "_wdata"},  cmd_wdata, 0);
    check({tag, "_error"},  cmd_error, ERR_NONE);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1);
  end

  initial begin
    forever begin
      @(posedge aclk);
      #1;
      ready_rnd = 1'($urandom_range(0, 1));
    end
  end

  // Transaction monitor: handshakes and error pulses are matched against expectation queues
  initial begin
    logic pv;
    logic pr;
    cmd_t prev;
    cmd_t e;
    pv = 1'b0;
    pr = 1'b0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        pv = 1'b0;
        continue;
      end
      if (pv && !pr && cmd_valid) begin
        check("hold_write", cmd_write, prev.w);
        check("hold_addr",  cmd_addr,  prev.a);
        check("hold_wdata", cmd_wdata, prev.d);
      end
      if (cmd_valid && cmd_ready) begin
        if (exp_cmd.size() == 0) begin
          check("spurious_cmd", cmd_valid, 0);
        end else begin
          e = exp_cmd.pop_front();
          check("cmd_write", cmd_write, e.w);
          check("cmd_addr",  cmd_addr,  e.a);
          check("cmd_wdata", cmd_wdata, e.d);
        end
      end
      if (cmd_error != ERR_NONE) begin
        if (exp_err.size() == 0) check("spurious_err", cmd_error, ERR_NONE);
        else check("cmd_error", cmd_error, exp_err.pop_front());
      end
      pv = cmd_valid;
      pr = cmd_ready;
      prev.w = cmd_write;
      prev.a = cmd_addr;
      prev.d = cmd_wdata;
    end
  end

  initial begin
    vec_t          vecs[9];
    int unsigned   kind;
    logic          is_wr;
    logic [7:0]    op;
    logic [DW-1:0] hdr, a, d;

    vecs[0] = '{32'hA5FFFFFF, 32'h00001004, 32'hDEADBEEF, 3, 0, 1'b1, 32'h00001004, 32'hDEADBEEF, ERR_NONE};
    vecs[1] = '{32'h5A123456, 32'h0000000C, 32'h0, 2, 0, 1'b0, 32'h0000000C, 32'h0, ERR_NONE};
    vecs[2] = '{32'h11223344, 32'h0, 32'h0, 1, 0, 1'b0, 32'h0, 32'h0, ERR_OPCODE};
    vecs[3] = '{32'hA4000000, 32'h0, 32'h0, 1, 0, 1'b0, 32'h0, 32'h0, ERR_OPCODE};
    vecs[4] = '{32'hA5000000, 32'h80000000, 32'h00000001, 3, 3, 1'b1, 32'h80000000, 32'h00000001, ERR_NONE};
    vecs[5] = '{32'hA5000000, 32'h0, 32'h0, 1, 0, 1'b0, 32'h0, 32'h0, ERR_TIMEOUT};
    vecs[6] = '{32'h5A000000, 32'hFFFFFFFF, 32'h0, 2, T - 1, 1'b0, 32'hFFFFFFFF, 32'h0, ERR_NONE};
    vecs[7] = '{32'hA5000000, 32'h00000044, 32'h0, 2, 1, 1'b0, 32'h0, 32'h0, ERR_TIMEOUT};
    vecs[8] = '{32'h5B000000, 32'h0, 32'h0, 1, 0, 1'b0, 32'h0, 32'h0, ERR_OPCODE};

    aresetn = 1'b0;
    repeat (3) step();
    check_reset_outputs("reset");
    aresetn = 1'b1;
    step();

    // Write with tvalid held: cmd_valid one cycle after the third word
    ready_man = 1'b1;
    exp_cmd.push_back('{1'b1, 32'h00001004, 32'hDEADBEEF});
    send_word(32'hA5000000);
    send_word(32'h00001004);
    check("wr_valid_early", cmd_valid, 0);
    send_word(32'hDEADBEEF);
    s_axis_tvalid = 1'b0;
    check("wr_valid", cmd_valid, 1);
    check("wr_write", cmd_write, 1);
    check("wr_addr", cmd_addr, 32'h00001004);
    check("wr_wdata", cmd_wdata, 32'hDEADBEEF);
    check("wr_tready_low", s_axis_tready, 0);
    step();
    check("wr_tready_back", s_axis_tready, 1);
    check("wr_valid_drop", cmd_valid, 0);

    // Read held off by cmd_ready for 10 cycles
    ready_man = 1'b0;
    exp_cmd.push_back('{1'b0, 32'h0000000C, 32'h0});
    send_word(32'h5A000000);
    send_word(32'h0000000C);
    s_axis_tvalid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("rd_hold_valid", cmd_valid, 1);
      check("rd_hold_tready", s_axis_tready, 0);
      check("rd_hold_write", cmd_write, 0);
      check("rd_hold_addr", cmd_addr, 32'h0000000C);
      check("rd_hold_wdata", cmd_wdata, 0);
      step();
    end
    ready_man = 1'b1;
    step();
    check("rd_done_valid", cmd_valid, 0);
    check("rd_done_tready", s_axis_tready, 1);

    // Bad opcode then a normal read
    exp_err.push_back(ERR_OPCODE);
    send_word(32'h11223344);
    s_axis_tvalid = 1'b0;
    check("bad_err", cmd_error, ERR_OPCODE);
    check("bad_valid", cmd_valid, 0);
    check("bad_tready", s_axis_tready, 1);
    step();
    check("bad_err_clear", cmd_error, ERR_NONE);
    exp_cmd.push_back('{1'b0, 32'h00000040, 32'h0});
    send_word(32'h5A000000);
    send_word(32'h00000040);
    wait_idle();

    // Timeout after header, then a read to address 0x20
    exp_err.push_back(ERR_TIMEOUT);
    send_word(32'hA5000000);
    idle(T - 1);
    check("to_err_before", cmd_error, ERR_NONE);
    idle(1);
    check("to_err", cmd_error, ERR_TIMEOUT);
    check("to_valid", cmd_valid, 0);
    step();
    check("to_err_clear", cmd_error, ERR_NONE);
    exp_cmd.push_back('{1'b0, 32'h00000020, 32'h0});
    send_word(32'h5A000000);
    send_word(32'h00000020);
    wait_idle();

    // Words arriving exactly on the counter limit cycle
    exp_cmd.push_back('{1'b1, 32'h000055AA, 32'hCAFEF00D});
    send_word(32'hA5000000);
    idle(T - 1);
    send_word(32'h000055AA);
    check("bnd_addr_err", cmd_error, ERR_NONE);
    idle(T - 1);
    send_word(32'hCAFEF00D);
    check("bnd_data_err", cmd_error, ERR_NONE);
    check("bnd_valid", cmd_valid, 1);
    wait_idle();

    // Reset while in DATA
    ready_man = 1'b0;
    send_word(32'hA5000000);
    send_word(32'h00000008);
    s_axis_tvalid = 1'b0;
    aresetn = 1'b0;
    step();
    check_reset_outputs("midrst");
    aresetn = 1'b1;
    ready_man = 1'b1;
    exp_cmd.push_back('{1'b1, 32'h00000100, 32'h12345678});
    send_word(32'hA5000000);
    send_word(32'h00000100);
    send_word(32'h12345678);
    wait_idle();

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].exp_err != ERR_NONE) exp_err.push_back(vecs[i].exp_err);
      else exp_cmd.push_back('{vecs[i].exp_write, vecs[i].exp_addr, vecs[i].exp_wdata});
      send_word(vecs[i].hdr);
      if (vecs[i].nwords > 1) begin
        idle(vecs[i].gap);
        send_word(vecs[i].addr);
      end
      if (vecs[i].nwords > 2) begin
        idle(vecs[i].gap);
        send_word(vecs[i].data);
      end
      if (vecs[i].exp_err == ERR_TIMEOUT) idle(T + 2);
      wait_idle();
    end

    ready_en = 1'b1;
    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 9);
      a = $urandom;
      d = $urandom;
      if (kind == 0) begin
        do op = 8'($urandom); while (op == WR_OP || op == RD_OP);
        hdr = {op, 24'($urandom)};
        exp_err.push_back(ERR_OPCODE);
        send_word(hdr);
      end else begin
        is_wr = 1'($urandom_range(0, 1));
        hdr = {(is_wr ? WR_OP : RD_OP), 24'($urandom)};
        if (kind == 1) begin
          exp_err.push_back(ERR_TIMEOUT);
          send_word(hdr);
          if (is_wr && $urandom_range(0, 1) == 1) begin
            idle($urandom_range(0, T - 1));
            send_word(a);
          end
          idle(T + 1 + $urandom_range(0, 3));
        end else begin
          exp_cmd.push_back('{is_wr, a, (is_wr ? d : '0)});
          send_word(hdr);
          idle($urandom_range(0, T - 1));
          send_word(a);
          if (is_wr) begin
            idle($urandom_range(0, T - 1));
            send_word(d);
          end
        end
      end
      idle($urandom_range(0, 4));
    end

    ready_en = 1'b0;
    ready_man = 1'b1;
    wait_idle();
    idle(3);
    check("cmd_queue_drained", exp_cmd.size(), 0);
    check("err_queue_drained", exp_err.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_cmd_decoder.md
Name: uart_cmd_decoder

Overview:
Sits directly downstream of the UART receiver's AXI-Stream master and consumes its received words. It assembles a header, address and optional data word into a single AXI-Lite command. The command goes to the AXI-Lite master FSM through a valid/ready request port. It also rejects malformed headers and abandons a command stalled between words after a timeout.

Parameters:
DATA_WIDTH, 32 (AXI_DATA_WIDTH_UART), width of stream words and of cmd_wdata
ADDR_WIDTH, 32 (AXI_ADDR_WIDTH), width of cmd_addr; taken from the address word's LSBs
TIMEOUT_CYCLES, 4*CLOCK/BAUD_RATE*DATA_BYTE*(2+DATA_BITS+STOP_BITS), maximum number of idle cycles allowed between words of one command

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-low reset
s_axis_tdata  in  DATA_WIDTH  received word from the UART RX stage
s_axis_tvalid  in  1  word valid
s_axis_tready  out  1  decoder can accept a word
cmd_valid  out  1  command available to the AXI-Lite master FSM
cmd_ready  in  1  AXI-Lite master FSM accepts the command
cmd_write  out  1  1 = write, 0 = read
cmd_addr  out  ADDR_WIDTH  target address
cmd_wdata  out  DATA_WIDTH  write data; 0 for reads
cmd_error  out  2  one-cycle error pulse: 00 none, 01 bad opcode, 10 timeout

Behaviour:
- Single clock aclk; reset is synchronous and active-low on aresetn. It applies whenever it is sampled low, including mid-command.
- Reset values: state=IDLE, s_axis_tready=1, cmd_valid=0, cmd_write=0, cmd_addr=0, cmd_wdata=0, cmd_error=00, timeout counter=0.
- A word is accepted on any cycle where s_axis_tvalid && s_axis_tready. s_axis_tready is registered: 1 in IDLE/ADDR/DATA, 0 in ISSUE.
- Header format: opcode = tdata[DATA_WIDTH-1 -: 8]. WR_OP=8'hA5, RD_OP=8'h5A. All other header bits are ignored.
- State machine:
  - IDLE: on an accepted header with WR_OP, cmd_write<=1 and go to ADDR. With RD_OP, cmd_write<=0 and go to ADDR. With any other opcode, stay in IDLE and pulse cmd_error=01 for one cycle.
  - ADDR: on an accepted word, cmd_addr<=tdata[ADDR_WIDTH-1:0]. If cmd_write, go to DATA. Otherwise cmd_wdata<=0, cmd_valid<=1, s_axis_tready<=0 and go to ISSUE.
  - DATA: on an accepted word, cmd_wdata<=tdata, cmd_valid<=1, s_axis_tready<=0 and go to ISSUE.
  - ISSUE: hold cmd_valid and all cmd_* fields stable until cmd_ready. On cmd_valid && cmd_ready: cmd_valid<=0, s_axis_tready<=1, go to IDLE. cmd_ready may be high in the same cycle cmd_valid first rises; the transfer then completes on that edge. cmd_ready while cmd_valid=0 is ignored.
- Latency:
  - Last accepted word to cmd_valid high: 1 cycle.
  - cmd handshake to s_axis_tready high again: 1 cycle.
- Timeout:
  - Counter runs only in ADDR and DATA. It clears on every accepted word and on entry to IDLE.
  - When the counter reaches TIMEOUT_CYCLES-1 with no word accepted, go to IDLE, clear the counter and pulse cmd_error=10. The partial command is dropped and cmd_valid is never asserted for it.
  - If a word is accepted in the same cycle the counter hits its limit, the word wins: the counter clears and no timeout occurs.
  - Counter width is $clog2(TIMEOUT_CYCLES). It saturates by construction and never wraps.
- cmd_error is high for exactly one cycle per event and returns to 00 the following cycle. Errors do not block subsequent headers.
- ISSUE has no timeout; the downstream FSM guarantees progress.

Decomposition:
- axil_pkg gains WR_OP, RD_OP, the cmd_error codes (ERR_NONE, ERR_OPCODE, ERR_TIMEOUT) and the typedef state_type_cmd {CMD_IDLE, CMD_ADDR, CMD_DATA, CMD_ISSUE}.
- TIMEOUT_CYCLES is derived from the existing CLOCK/BAUD_RATE/DATA_BITS/STOP_BITS package constants.
- No sub-module: a single FSM plus counter. The timeout counter stays inline.

Test Plan:
- Write: stream A5000000, 00001004, DEADBEEF with tvalid held → cmd_valid rises 1 cycle after the third word, with cmd_write=1, cmd_addr=00001004, cmd_wdata=DEADBEEF. With cmd_ready high, s_axis_tready=1 two cycles after the third word.
- Read: stream 5A000000, 0000000C → cmd_write=0, cmd_addr=0000000C, cmd_wdata=0. Hold cmd_ready=0 for 10 cycles → fields stable, s_axis_tready=0 throughout, handshake completes when cmd_ready=1.
- Bad opcode: header 11223344 → cmd_error=01 for exactly 1 cycle, state stays IDLE, no cmd_valid. A following valid read command decodes normally.
- Timeout: A5000000, then no word for TIMEOUT_CYCLES cycles → cmd_error=10 pulse, no cmd_valid. Next 5A000000, 00000020 produces a read to address 20.
- Timeout boundary: deliver the address word exactly on the cycle the counter equals TIMEOUT_CYCLES-1 → no error, command completes.
- Reset mid-command: deassert aresetn in DATA state → next cycle all outputs at reset values, s_axis_tready=1. A new write command then completes correctly.
